// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grants of up to CDB_WIDTH pending
// FU results per cycle, registered onto the CDB broadcast slots.
// Ports:
//   clock, reset (sync, active-high), flush (squash grants, reset pointer)
//   fu_valid/fu_value/fu_value_valid/fu_dest_prf/fu_rob_entry/
//   fu_branch_address : per-FU result inputs
//   fu_sel            : same-cycle grant back to each FU
//   cdb_valid/cdb_value/cdb_write_prf/cdb_dest_prf/cdb_rob_entry/
//   cdb_branch_address: registered broadcast slots, one cycle after grant
module cdb_arbiter #(
   parameter int NUM_FU    = 4,
   parameter int CDB_WIDTH = 2,
   parameter int XLEN      = 32,
   parameter int PRF_W     = 6,
   parameter int ROB_W     = 5
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                flush,
   input  logic [NUM_FU-1:0]                   fu_valid,
   input  logic [NUM_FU-1:0][XLEN-1:0]         fu_value,
   input  logic [NUM_FU-1:0]                   fu_value_valid,
   input  logic [NUM_FU-1:0][PRF_W-1:0]        fu_dest_prf,
   input  logic [NUM_FU-1:0][ROB_W-1:0]        fu_rob_entry,
   input  logic [NUM_FU-1:0][XLEN-1:0]         fu_branch_address,
   output logic [NUM_FU-1:0]                   fu_sel,
   output logic [CDB_WIDTH-1:0]                cdb_valid,
   output logic [CDB_WIDTH-1:0][XLEN-1:0]      cdb_value,
   output logic [CDB_WIDTH-1:0]                cdb_write_prf,
   output logic [CDB_WIDTH-1:0][PRF_W-1:0]     cdb_dest_prf,
   output logic [CDB_WIDTH-1:0][ROB_W-1:0]     cdb_rob_entry,
   output logic [CDB_WIDTH-1:0][XLEN-1:0]      cdb_branch_address
);

   localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int SLOT_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

   logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
   logic [CDB_WIDTH-1:0]              slot_hit;
   logic [CDB_WIDTH-1:0][PTR_W-1:0]   slot_fu;

   logic [CDB_WIDTH-1:0]              valid_q, valid_d;
   logic [CDB_WIDTH-1:0]              wprf_q, wprf_d;
   logic [CDB_WIDTH-1:0][XLEN-1:0]    value_q, value_d;
   logic [CDB_WIDTH-1:0][PRF_W-1:0]   dest_q, dest_d;
   logic [CDB_WIDTH-1:0][ROB_W-1:0]   rob_q, rob_d;
   logic [CDB_WIDTH-1:0][XLEN-1:0]    br_q, br_d;

   // Rotating scan starting at rr_ptr; the k-th valid FU found fills slot k.
   always_comb begin : grant_scan
      int idx;
      int cnt;
      fu_sel   = '0;
      slot_hit = '0;
      slot_fu  = '0;
      rr_ptr_d = rr_ptr_q;
      cnt      = 0;
      idx      = 0;
      for (int j = 0; j < NUM_FU; j++) begin
         idx = int'(rr_ptr_q) + j;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (fu_valid[PTR_W'(idx)] && cnt < CDB_WIDTH) begin
            fu_sel[PTR_W'(idx)]    = 1'b1;
            slot_hit[SLOT_W'(cnt)] = 1'b1;
            slot_fu[SLOT_W'(cnt)]  = PTR_W'(idx);
            cnt = cnt + 1;
            rr_ptr_d = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
      // Squash and reset both kill every grant this cycle.
      if (reset || flush) begin
         fu_sel   = '0;
         slot_hit = '0;
         rr_ptr_d = '0;
      end
   end

   // Empty slots keep their data; only valid/write_prf drop.
   always_comb begin
      valid_d = slot_hit;
      wprf_d  = '0;
      value_d = value_q;
      dest_d  = dest_q;
      rob_d   = rob_q;
      br_d    = br_q;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         if (slot_hit[k]) begin
            wprf_d[k]  = fu_value_valid[slot_fu[k]];
            value_d[k] = fu_value[slot_fu[k]];
            dest_d[k]  = fu_dest_prf[slot_fu[k]];
            rob_d[k]   = fu_rob_entry[slot_fu[k]];
            br_d[k]    = fu_branch_address[slot_fu[k]];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q <= '0;
         valid_q  <= '0;
         wprf_q   <= '0;
         value_q  <= '0;
         dest_q   <= '0;
         rob_q    <= '0;
         br_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         valid_q  <= valid_d;
         wprf_q   <= wprf_d;
         value_q  <= value_d;
         dest_q   <= dest_d;
         rob_q    <= rob_d;
         br_q     <= br_d;
      end
   end

   assign cdb_valid          = valid_q;
   assign cdb_write_prf      = wprf_q;
   assign cdb_value          = value_q;
   assign cdb_dest_prf       = dest_q;
   assign cdb_rob_entry      = rob_q;
   assign cdb_branch_address = br_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner
// sequences, and randomized traffic against a round-robin reference model.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int W  = 2;
   localparam int XL = 32;
   localparam int PW = 6;
   localparam int RW = 5;

   logic clock = 1'b0;
   logic reset, flush;
   logic [N-1:0]          fu_valid, fu_value_valid, fu_sel;
   logic [N-1:0][XL-1:0]  fu_value, fu_branch_address;
   logic [N-1:0][PW-1:0]  fu_dest_prf;
   logic [N-1:0][RW-1:0]  fu_rob_entry;
   logic [W-1:0]          cdb_valid, cdb_write_prf;
   logic [W-1:0][XL-1:0]  cdb_value, cdb_branch_address;
   logic [W-1:0][PW-1:0]  cdb_dest_prf;
   logic [W-1:0][RW-1:0]  cdb_rob_entry;

   int checks = 0;
   int errors = 0;

   cdb_arbiter #(
      .NUM_FU(N), .CDB_WIDTH(W), .XLEN(XL), .PRF_W(PW), .ROB_W(RW)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .fu_valid(fu_valid), .fu_value(fu_value),
      .fu_value_valid(fu_value_valid), .fu_dest_prf(fu_dest_prf),
      .fu_rob_entry(fu_rob_entry), .fu_branch_address(fu_branch_address),
      .fu_sel(fu_sel), .cdb_valid(cdb_valid), .cdb_value(cdb_value),
      .cdb_write_prf(cdb_write_prf), .cdb_dest_prf(cdb_dest_prf),
      .cdb_rob_entry(cdb_rob_entry),
      .cdb_branch_address(cdb_branch_address)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       flush;
      logic [3:0] v;
      logic [3:0] vv;
      logic [3:0] sel;
      logic [1:0] cv;
      logic [1:0] wp;
      int         s0;
      int         s1;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] fu_fields(int i);
      logic [1:0] f;
      f = i[1:0];
      return 128'({fu_value[f], fu_branch_address[f],
                   fu_dest_prf[f], fu_rob_entry[f]});
   endfunction

   function automatic logic [127:0] cdb_fields(int k);
      logic s;
      s = k[0];
      return 128'({cdb_value[s], cdb_branch_address[s],
                   cdb_dest_prf[s], cdb_rob_entry[s]});
   endfunction

   task automatic set_fields(int tag);
      for (int i = 0; i < N; i++) begin
         fu_value[i[1:0]]          = 32'hA000_0000 | 32'(tag << 8) | 32'(i);
         fu_branch_address[i[1:0]] = 32'h0040_0000 + 32'(tag * 16 + i * 4);
         fu_dest_prf[i[1:0]]       = 6'((tag * 4 + i) % 64);
         fu_rob_entry[i[1:0]]      = 5'((tag + i) % 32);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      flush = 1'b0;
      fu_valid = '0;
      fu_value_valid = '0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Reference model state for random traffic.
   int          rr;
   logic [N-1:0] pend;
   int          age[N];
   int          slot_i[W];
   logic [127:0] ef[W];

   initial begin
      logic [127:0] e0, e1;
      logic [N-1:0] exp_sel;
      logic [W-1:0] exp_cv, exp_wp;
      int nq, mx;

      tbl[0]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b00, -1, -1};
      tbl[1]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b00, -1, -1};
      tbl[2]  = '{1'b0, 4'b1011, 4'b1111, 4'b0011, 2'b11, 2'b11,  0,  1};
      tbl[3]  = '{1'b0, 4'b0100, 4'b1111, 4'b0100, 2'b01, 2'b01,  2, -1};
      tbl[4]  = '{1'b0, 4'b1001, 4'b1111, 4'b1001, 2'b11, 2'b11,  3,  0};
      tbl[5]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 2'b01, 2'b00,  2, -1};
      tbl[6]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 2'b00, -1, -1};
      tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b0011, 2'b11, 2'b11,  0,  1};
      tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b1100, 2'b11, 2'b11,  2,  3};
      tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 4'b0011, 2'b11, 2'b11,  0,  1};
      tbl[10] = '{1'b0, 4'b1111, 4'b1111, 4'b1100, 2'b11, 2'b11,  2,  3};
      tbl[11] = '{1'b0, 4'b1111, 4'b0101, 4'b0011, 2'b11, 2'b01,  0,  1};
      tbl[12] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b00, -1, -1};
      tbl[13] = '{1'b0, 4'b0001, 4'b1111, 4'b0001, 2'b01, 2'b01,  0, -1};
      tbl[14] = '{1'b0, 4'b1110, 4'b1111, 4'b0110, 2'b11, 2'b11,  1,  2};
      tbl[15] = '{1'b0, 4'b0010, 4'b1111, 4'b0010, 2'b01, 2'b01,  1, -1};

      // Reset state, with FUs requesting during reset.
      reset = 1'b1;
      flush = 1'b0;
      fu_valid = 4'b1111;
      fu_value_valid = 4'b1111;
      set_fields(0);
      repeat (2) @(posedge clock);
      #1;
      chk("rst_sel", 128'(fu_sel), 128'(4'b0000));
      chk("rst_cv", 128'(cdb_valid), 128'(2'b00));
      chk("rst_wp", 128'(cdb_write_prf), 128'(2'b00));
      chk("rst_s0", cdb_fields(0), 128'(0));
      chk("rst_s1", cdb_fields(1), 128'(0));
      @(negedge clock);
      reset = 1'b0;
      fu_valid = '0;

      // Directed vector table, run back to back from the reset pointer.
      for (int t = 0; t < 16; t++) begin
         @(negedge clock);
         flush = tbl[t].flush;
         fu_valid = tbl[t].v;
         fu_value_valid = tbl[t].vv;
         set_fields(t + 1);
         #1;
         chk($sformatf("t%0d_sel", t), 128'(fu_sel), 128'(tbl[t].sel));
         e0 = fu_fields(tbl[t].s0);
         e1 = fu_fields(tbl[t].s1);
         @(posedge clock);
         #1;
         chk($sformatf("t%0d_cv", t), 128'(cdb_valid), 128'(tbl[t].cv));
         chk($sformatf("t%0d_wp", t), 128'(cdb_write_prf), 128'(tbl[t].wp));
         if (tbl[t].cv[0]) chk($sformatf("t%0d_s0", t), cdb_fields(0), e0);
         if (tbl[t].cv[1]) chk($sformatf("t%0d_s1", t), cdb_fields(1), e1);
      end

      // Non-writing result still broadcasts, and empty slot holds data.
      do_reset();
      fu_valid = 4'b0100;
      fu_value_valid = 4'b0000;
      set_fields(50);
      fu_value[2] = 32'h0000_1234;
      #1;
      chk("nw_sel", 128'(fu_sel), 128'(4'b0100));
      @(posedge clock);
      #1;
      chk("nw_cv", 128'(cdb_valid), 128'(2'b01));
      chk("nw_wp", 128'(cdb_write_prf), 128'(2'b00));
      chk("nw_val", 128'(cdb_value[0]), 128'(32'h1234));
      @(negedge clock);
      fu_valid = 4'b0000;
      fu_value[2] = 32'h0000_9999;
      @(posedge clock);
      #1;
      chk("hold_cv", 128'(cdb_valid), 128'(2'b00));
      chk("hold_val", 128'(cdb_value[0]), 128'(32'h1234));

      // Reset mid-operation discards the grant.
      @(negedge clock);
      fu_valid = 4'b1111;
      fu_value_valid = 4'b1111;
      reset = 1'b1;
      #1;
      chk("mrst_sel", 128'(fu_sel), 128'(4'b0000));
      @(posedge clock);
      #1;
      chk("mrst_cv", 128'(cdb_valid), 128'(2'b00));
      chk("mrst_val", 128'(cdb_value[0]), 128'(0));
      @(negedge clock);
      reset = 1'b0;
      fu_valid = 4'b0000;
      @(posedge clock);
      #1;
      chk("mrst_cv2", 128'(cdb_valid), 128'(2'b00));
      @(negedge clock);
      fu_valid = 4'b1111;
      #1;
      chk("mrst_ptr", 128'(fu_sel), 128'(4'b0011));
      @(posedge clock);

      // Randomized traffic: FUs hold results until granted.
      do_reset();
      rr = 0;
      pend = '0;
      for (int i = 0; i < N; i++) age[i] = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clock);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               age[i] = 0;
               fu_value[i[1:0]] = $urandom;
               fu_branch_address[i[1:0]] = $urandom;
               fu_dest_prf[i[1:0]] = 6'($urandom);
               fu_rob_entry[i[1:0]] = 5'($urandom);
               fu_value_valid[i[1:0]] = 1'($urandom);
            end
         end
         flush = ($urandom_range(15, 0) == 0);
         fu_valid = pend;
         exp_sel = '0;
         exp_cv = '0;
         exp_wp = '0;
         nq = 0;
         for (int d = 0; d < N; d++) begin
            int i;
            i = (rr + d) % N;
            if (pend[i] && nq < W) begin
               exp_sel[i] = 1'b1;
               slot_i[nq] = i;
               nq++;
            end
         end
         if (flush) begin
            exp_sel = '0;
            nq = 0;
         end
         for (int k = 0; k < W; k++) begin
            if (k < nq) begin
               exp_cv[k] = 1'b1;
               exp_wp[k] = fu_value_valid[slot_i[k]];
               ef[k] = fu_fields(slot_i[k]);
            end
         end
         #1;
         chk($sformatf("r%0d_sel", c), 128'(fu_sel), 128'(exp_sel));
         @(posedge clock);
         if (flush) begin
            rr = 0;
            pend = '0;
         end else begin
            if (nq > 0) rr = (slot_i[nq - 1] + 1) % N;
            pend = pend & ~exp_sel;
         end
         mx = 0;
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               age[i]++;
               if (age[i] > mx) mx = age[i];
            end
         end
         #1;
         chk($sformatf("r%0d_cv", c), 128'(cdb_valid), 128'(exp_cv));
         chk($sformatf("r%0d_wp", c), 128'(cdb_write_prf), 128'(exp_wp));
         for (int k = 0; k < W; k++) begin
            if (exp_cv[k]) chk($sformatf("r%0d_s%0d", c, k), cdb_fields(k), ef[k]);
         end
         // A pending FU must be served in its first or second cycle.
         if (mx > 1) chk($sformatf("r%0d_starve", c), 128'(mx), 128'(1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
